// File: rtl/spi_slave_stream.sv
// SPI slave: header + DATA_W payload frames into register files and a pixel stream FIFO.
// Optional status word/counters compiled in with SPI_STATUS_EN.
module spi_slave_stream #(
  parameter int         DATA_W      = 32,
  parameter int         NREGS       = 16,
  parameter int         PIX_W       = 24,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         CPOL        = 0,
  parameter logic [6:0] PIX_ADDR    = 7'h7E,
  parameter logic [6:0] STATUS_ADDR = 7'h7F
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iSPI_CLK,
  input  logic                     iSPI_CS,
  input  logic                     iSPI_MOSI,
  output logic                     oSPI_MISO,
  input  logic                     iData_WE,
  input  logic [$clog2(NREGS)-1:0] iData_Addr,
  input  logic [DATA_W-1:0]        iData_Write,
  output logic [DATA_W-1:0]        oData_Read,
  output logic [PIX_W-1:0]         oPix_Data,
  output logic                     oPix_Valid,
  input  logic                     iPix_Ready,
  output logic                     oFrame_Err
);

  localparam int   AW  = $clog2(NREGS);
  localparam int   FW  = $clog2(FIFO_DEPTH);
  localparam int   F   = 8 + DATA_W;
  localparam int   CW  = $clog2(F + 1);
  localparam logic POL = (CPOL != 0);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    DONE
  } state_e;

  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sclk_q <= {3{POL}};
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], iSPI_CLK};
      cs_q   <= {cs_q[1:0], iSPI_CS};
      mosi_q <= {mosi_q[0], iSPI_MOSI};
    end
  end

  logic s_rise, s_fall, lead, trail;
  logic cs_fall, cs_hi, mosi;

  assign s_rise  = ~sclk_q[2] & sclk_q[1];
  assign s_fall  = sclk_q[2] & ~sclk_q[1];
  assign lead    = POL ? s_fall : s_rise;
  assign trail   = POL ? s_rise : s_fall;
  assign cs_fall = cs_q[2] & ~cs_q[1];
  assign cs_hi   = cs_q[1];
  assign mosi    = mosi_q[1];

  logic [DATA_W-1:0] mosi_ram [NREGS];
  logic [DATA_W-1:0] miso_ram [NREGS];

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        hdr_q, hdr_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              err_q, err_d;
  logic              commit_q, commit_d;

  logic              in_rng, is_stat, is_pix;
  logic [DATA_W-1:0] load_v;

  assign in_rng = hdr_q[6:0] < 7'(NREGS);
  assign is_stat = hdr_q[6:0] == STATUS_ADDR;
  assign is_pix = hdr_q[6:0] == PIX_ADDR;

  logic [FW:0]   lvl_q, lvl_d;
  logic [FW-1:0] wr_q, wr_d;
  logic [FW-1:0] rd_q, rd_d;
  logic          push, pop, full, acc;

`ifdef SPI_STATUS_EN
  logic       ovf_q, ovf_d;
  logic [7:0] abrt_q, abrt_d;
  logic       clr;
  logic [DATA_W-1:0] status;

  assign clr = commit_q & hdr_q[7] & is_stat & rx_q[0];
  assign status = DATA_W'({ovf_q, abrt_q, lvl_q});

  always_comb begin
    ovf_d  = ovf_q;
    abrt_d = abrt_q;
    if (clr) begin
      ovf_d  = 1'b0;
      abrt_d = '0;
    end else begin
      if (push && full && !pop) ovf_d = 1'b1;
      if (err_q && abrt_q != 8'hFF) abrt_d = abrt_q + 8'd1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      ovf_q  <= 1'b0;
      abrt_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      abrt_q <= abrt_d;
    end
  end

  always_comb begin
    load_v = '0;
    if (!hdr_q[7]) begin
      if (in_rng) load_v = miso_ram[hdr_q[AW-1:0]];
      else if (is_stat) load_v = status;
    end
  end
`else
  always_comb begin
    load_v = '0;
    if (!hdr_q[7] && in_rng && !is_stat)
      load_v = miso_ram[hdr_q[AW-1:0]];
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    err_d    = 1'b0;
    commit_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = HDR;
          cnt_d   = '0;
          hdr_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
          miso_d  = 1'b0;
        end
      end
      HDR: begin
        if (cs_hi) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (lead) begin
          hdr_d = {hdr_q[6:0], mosi};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(7)) state_d = DATA;
        end
      end
      DATA: begin
        if (cs_hi) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (lead) begin
          rx_d  = {rx_q[DATA_W-2:0], mosi};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(F - 1)) begin
            state_d  = DONE;
            commit_d = 1'b1;
          end
        end else if (trail) begin
          // first trailing edge after the header loads the reply word
          if (cnt_q == CW'(8)) begin
            miso_d = load_v[DATA_W-1];
            tx_d   = load_v << 1;
          end else begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
          end
        end
      end
      DONE: begin
        if (cs_hi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hdr_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      miso_q   <= 1'b0;
      err_q    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      miso_q   <= miso_d;
      err_q    <= err_d;
      commit_q <= commit_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iData_WE) miso_ram[iData_Addr] <= iData_Write;
  end

  always_ff @(posedge iCLK) begin
    if (commit_q && hdr_q[7] && in_rng)
      mosi_ram[hdr_q[AW-1:0]] <= rx_q;
  end

  logic [PIX_W-1:0] fifo_q [FIFO_DEPTH];

  assign push = commit_q & hdr_q[7] & is_pix;
  assign pop  = oPix_Valid & iPix_Ready;
  assign full = lvl_q == (FW+1)'(FIFO_DEPTH);
  assign acc  = push & (~full | pop);

  always_comb begin
    wr_d  = acc ? wr_q + FW'(1) : wr_q;
    rd_d  = pop ? rd_q + FW'(1) : rd_q;
    lvl_d = lvl_q;
    if (acc && !pop) lvl_d = lvl_q + (FW+1)'(1);
    else if (!acc && pop) lvl_d = lvl_q - (FW+1)'(1);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      lvl_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      lvl_q <= lvl_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (acc) fifo_q[wr_q] <= rx_q[PIX_W-1:0];
  end

  assign oPix_Valid = lvl_q != '0;
  assign oPix_Data  = oPix_Valid ? fifo_q[rd_q] : '0;
  assign oData_Read = mosi_ram[iData_Addr];
  assign oSPI_MISO  = miso_q;
  assign oFrame_Err = err_q;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench for spi_slave_stream; two instances share stimulus,
// one CPOL=0 and one CPOL=1 driven with the inverted SPI clock.
module tb_spi_slave_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        ready = 1'b0;

  logic        miso0, miso1;
  logic [31:0] rd0, rd1;
  logic [23:0] pd0, pd1;
  logic        pv0, pv1;
  logic        err0, err1;

  int n_cmp = 0;
  int n_fail = 0;
  int errc = 0;
  int e0;
  logic [31:0] rx0, rx1;

  always #5 clk = ~clk;

  always @(negedge clk) if (err0) errc++;

  spi_slave_stream #(.CPOL(0)) dut0 (
    .iCLK(clk), .iRST(rst), .iSPI_CLK(sclk), .iSPI_CS(cs),
    .iSPI_MOSI(mosi), .oSPI_MISO(miso0), .iData_WE(we),
    .iData_Addr(addr), .iData_Write(wdata), .oData_Read(rd0),
    .oPix_Data(pd0), .oPix_Valid(pv0), .iPix_Ready(ready),
    .oFrame_Err(err0)
  );

  spi_slave_stream #(.CPOL(1)) dut1 (
    .iCLK(clk), .iRST(rst), .iSPI_CLK(~sclk), .iSPI_CS(cs),
    .iSPI_MOSI(mosi), .oSPI_MISO(miso1), .iData_WE(we),
    .iData_Addr(addr), .iData_Write(wdata), .oData_Read(rd1),
    .oPix_Data(pd1), .oPix_Valid(pv1), .iPix_Ready(ready),
    .oFrame_Err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [39:0] fr, input int nb);
    for (int i = 0; i < nb; i++) begin
      mosi = fr[39-i];
      #50;
      if (i >= 8) begin
        rx0 = {rx0[30:0], miso0};
        rx1 = {rx1[30:0], miso1};
      end
      sclk = 1'b1;
      #50;
      sclk = 1'b0;
    end
    #50;
  endtask

  task automatic cs_low();
    rx0 = '0;
    rx1 = '0;
    cs = 1'b0;
    #50;
  endtask

  task automatic cs_high();
    cs = 1'b1;
    mosi = 1'b0;
    #100;
  endtask

  task automatic frame(input logic [7:0] h, input logic [31:0] p);
    cs_low();
    spi_bits({h, p}, 40);
    cs_high();
  endtask

  task automatic av_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_miso0", 32'(miso0), 32'h0);
    chk("rst_miso1", 32'(miso1), 32'h0);
    chk("rst_valid", 32'(pv0), 32'h0);
    chk("rst_pdata", 32'(pd0), 32'h0);
    chk("rst_err", 32'(err0), 32'h0);
    repeat (2) @(negedge clk);

    // register write frame
    e0 = errc;
    frame(8'h83, 32'hDEADBEEF);
    addr = 4'd3;
    #1;
    chk("wr_reg3_cpol0", rd0, 32'hDEADBEEF);
    chk("wr_reg3_cpol1", rd1, 32'hDEADBEEF);
    chk("wr_fifo_idle", 32'(pv0), 32'h0);
    chk("wr_no_err", 32'(errc - e0), 32'h0);
    @(negedge clk);

    // register read frames
    av_write(4'd5, 32'h12345678);
    frame(8'h05, 32'h0);
    chk("rd5_cpol0", rx0, 32'h12345678);
    chk("rd5_cpol1", rx1, 32'h12345678);
    frame(8'h20, 32'h0);
    chk("rd_oob", rx0, 32'h0);
    frame(8'h7F, 32'h0);
    chk("rd_status_empty", rx0, 32'h0);

    // pixel stream, three frames then drain
    frame(8'hFE, 32'h00AABBCC);
    frame(8'hFE, 32'h00112233);
    frame(8'hFE, 32'h00445566);
    @(negedge clk);
    chk("pix_valid", 32'(pv0), 32'h1);
    chk("pix_head", 32'(pd0), 32'h00AABBCC);
    ready = 1'b1;
    chk("pop0", 32'(pd0), 32'h00AABBCC);
    @(negedge clk);
    chk("pop1", 32'(pd0), 32'h00112233);
    @(negedge clk);
    chk("pop2", 32'(pd0), 32'h00445566);
    @(negedge clk);
    ready = 1'b0;
    chk("pix_empty", 32'(pv0), 32'h0);
    chk("pix_empty_data", 32'(pd0), 32'h0);

    // overflow: ten pixels into eight entries
    for (int k = 1; k <= 10; k++)
      frame(8'hFE, 32'(k) * 32'h00010101);
`ifdef SPI_STATUS_EN
    frame(8'h7F, 32'h0);
    chk("status_ovf", rx0, 32'h00001008);
`endif
    @(negedge clk);
    ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("ovf_valid", 32'(pv0), 32'h1);
      chk("ovf_pop", 32'(pd0), 32'(k) * 32'h00010101);
      @(negedge clk);
    end
    ready = 1'b0;
    chk("ovf_drained", 32'(pv0), 32'h0);

    // abort mid-frame
    frame(8'h82, 32'h11111111);
    e0 = errc;
    cs_low();
    spi_bits({8'h82, 32'hCAFEF00D}, 20);
    cs_high();
    addr = 4'd2;
    #1;
    chk("abort_keep", rd0, 32'h11111111);
    chk("abort_err1", 32'(errc - e0), 32'h1);
    @(negedge clk);
    e0 = errc;
    frame(8'h82, 32'h22222222);
    addr = 4'd2;
    #1;
    chk("after_abort", rd0, 32'h22222222);
    chk("after_abort_noerr", 32'(errc - e0), 32'h0);
    @(negedge clk);

    // reset mid-data with CS held low
    av_write(4'd6, 32'hFFFFFFFF);
    frame(8'hFE, 32'h00000777);
    @(negedge clk);
    chk("pre_rst_valid", 32'(pv0), 32'h1);
    cs_low();
    spi_bits({8'h06, 32'h0}, 20);
    chk("pre_rst_miso", 32'(miso0), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_miso", 32'(miso0), 32'h0);
    chk("rst_mid_valid", 32'(pv0), 32'h0);
    e0 = errc;
    spi_bits({8'h06, 32'h0}, 20);
    chk("rst_ignored_miso", 32'(miso0), 32'h0);
    cs_high();
    chk("rst_tail_valid", 32'(pv0), 32'h0);
    chk("rst_tail_noerr", 32'(errc - e0), 32'h0);
    frame(8'hFE, 32'h00ABCDEF);
    @(negedge clk);
    chk("new_frame_valid", 32'(pv0), 32'h1);
    chk("new_frame_data", 32'(pd0), 32'h00ABCDEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_stream.md
Name: spi_slave_stream

Overview:
- Parametrised successor to the project's single-width SPI slave (Raspberry Pi master → FPGA).
- Generalised in three ways:
  - Frame width is configurable (8-bit header + DATA_W payload).
  - Register file depth is configurable.
  - SPI clock polarity is selectable.
- Pixel writes are buffered in a FIFO and delivered on a valid/ready stream to the SDRAM/MTL writer, instead of a one-cycle trigger pulse.
- The Avalon-side register read/write port is retained.

Parameters:
- DATA_W, 32: payload bits per frame; must be ≥ PIX_W and ≤ 32.
- NREGS, 16: entries in each of the MOSI and MISO register files; power of 2, ≤ 64.
- PIX_W, 24: pixel width pushed to the stream.
- FIFO_DEPTH, 8: pixel FIFO entries; power of 2, ≥ 2.
- CPOL, 0: SPI clock idle level. Data is sampled on the leading edge and shifted out on the trailing edge (CPHA=0 only).
- PIX_ADDR, 7'h7E: header address that routes the payload to the pixel FIFO.
- STATUS_ADDR, 7'h7F: header address of the status word (used only when the optional feature is compiled in).

Ports:
- iCLK  in  1  system clock. Single clock domain; iCLK must be ≥ 4× SPI clock.
- iRST  in  1  reset, synchronous, active-high.
- iSPI_CLK  in  1  SPI clock (asynchronous).
- iSPI_CS  in  1  SPI chip select, active-low (asynchronous).
- iSPI_MOSI  in  1  SPI MOSI.
- oSPI_MISO  out  1  SPI MISO.
- iData_WE  in  1  Avalon write strobe into the MISO register file.
- iData_Addr  in  $clog2(NREGS)  Avalon register address.
- iData_Write  in  DATA_W  Avalon write data.
- oData_Read  out  DATA_W  combinational read of the MOSI register file at iData_Addr.
- oPix_Data  out  PIX_W  pixel at the FIFO head.
- oPix_Valid  out  1  FIFO not empty.
- iPix_Ready  in  1  consumer accepts the head pixel.
- oFrame_Err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Synchronisation
  - iSPI_CLK, iSPI_CS and iSPI_MOSI each pass through a 2-flop synchroniser.
  - Edges are detected from the 2nd vs 3rd flop.
  - Leading edge = rise if CPOL=0, fall if CPOL=1.
- Frame format
  - Header bit 7: 1 = write, 0 = read. Bits 6:0: address.
  - Then DATA_W payload bits, MSB first.
  - Frame length F = 8 + DATA_W.
- FSM: IDLE → HDR → DATA → DONE.
  - IDLE: on CS fall, clear the bit counter and shift register, drive MISO=0, go to HDR.
  - HDR: shift one MOSI bit on each leading edge. After 8 bits, latch the header and go to DATA.
    - Read with address < NREGS: load misoRAM[addr] into the TX shift register on the trailing edge after bit 8.
    - Read with any other address: load 0.
  - DATA:
    - Shift MOSI in on each leading edge.
    - On each trailing edge, drive MISO with the TX MSB, then shift TX left.
    - After F bits, go to DONE and commit on the next cycle:
      - Write, address < NREGS: mosiRAM[addr] ← payload.
      - Write, address = PIX_ADDR: push payload[PIX_W-1:0] to the FIFO.
      - Write, any other address: ignored.
      - Read: no state change.
  - DONE: ignore further SPI clocks until CS rises, then go to IDLE.
  - CS rise in HDR or DATA: abort, no commit, pulse oFrame_Err, go to IDLE. CS high has priority over any edge in the same cycle.
- MISO
  - Reset value 0.
  - Holds its value while CS is high.
  - Bit 0 of the payload is valid before the 1st payload leading edge.
- FIFO
  - Pop when oPix_Valid && iPix_Ready.
  - Push and pop in the same cycle are allowed when not empty; the count is unchanged.
  - Push when full: the pixel is dropped and overflow_sticky is set.
    - Exception: a simultaneous pop makes room, and the push is accepted.
  - oPix_Data is valid and stable whenever oPix_Valid=1. It is 0 when empty.
- Register file
  - An Avalon write and an SPI read of the same misoRAM entry can coincide. If the Avalon write lands before the TX load cycle, the TX load sees the new data.
  - mosiRAM is not reset; its contents are 0 after power-up only in simulation.
- Reset values: FSM=IDLE, FIFO empty, oPix_Valid=0, oPix_Data=0, oSPI_MISO=0, oFrame_Err=0, overflow_sticky=0.
  - Reset mid-frame returns to IDLE. The frame still in progress is discarded even if CS remains low; the next CS fall starts a new frame.

Optional Feature:
- Macro: SPI_STATUS_EN.
- When defined:
  - A read frame to STATUS_ADDR returns {overflow_sticky, abort_cnt[7:0], fifo_level[$clog2(FIFO_DEPTH):0]}, zero-extended to DATA_W.
  - abort_cnt saturates at 255.
  - A write frame to STATUS_ADDR with payload bit 0 = 1 clears overflow_sticky and abort_cnt.
- When undefined:
  - Reads of STATUS_ADDR return 0 and writes are ignored.
  - The overflow and abort counters are not synthesised.

Test Plan:
- Write frame hdr=8'h83, payload 32'hDEADBEEF, then CS high → oData_Read at iData_Addr=3 is 32'hDEADBEEF; FIFO unchanged; no oFrame_Err.
- Avalon write misoRAM[5]=32'h12345678, then SPI read frame hdr=8'h05 → MISO payload bits decode to 32'h12345678. Run with both CPOL=0 and CPOL=1.
- 3 write frames to PIX_ADDR with payloads 32'h00AABBCC, 32'h00112233, 32'h00445566, iPix_Ready held 0 → oPix_Valid=1, head 24'hAABBCC. Then iPix_Ready=1 → 3 pops in order, then oPix_Valid=0.
- FIFO_DEPTH+2 pixel frames with iPix_Ready=0 → first 8 pixels retained, last 2 dropped. With SPI_STATUS_EN, a status read shows overflow_sticky=1 and fifo_level=8.
- CS raised after 20 bits of a write to address 2 → mosiRAM[2] unchanged; oFrame_Err pulses for exactly 1 cycle; the next full frame to address 2 commits correctly.
- iRST asserted mid-DATA with CS low → oSPI_MISO=0 and FIFO empty; the frame is not committed; a new CS fall then starts a clean frame.
